// File: rtl/bb_adc_seq_if.sv
// BB ADC burst sequencer bus.
// Groups the clock enable, the readout strobe/qualifier, the ADC busy line and the
// sequencer results into one bundle.
//   master : environment side (readout logic + ADC chip) - drives CE, STROBE, READBB, ADCBUSY
//   slave  : sequencer side - drives BBCONV, DATAREADY, CONV_IDX, TMO_ERR
interface bb_adc_seq_if #(
  parameter int unsigned IW = 4
);
  logic          CE;
  logic          STROBE;
  logic          READBB;
  logic          ADCBUSY;
  logic          BBCONV;
  logic          DATAREADY;
  logic [IW-1:0] CONV_IDX;
  logic          TMO_ERR;

  modport master (
    output CE, STROBE, READBB, ADCBUSY,
    input  BBCONV, DATAREADY, CONV_IDX, TMO_ERR
  );

  modport slave (
    input  CE, STROBE, READBB, ADCBUSY,
    output BBCONV, DATAREADY, CONV_IDX, TMO_ERR
  );
endinterface

// File: rtl/bb_adc_seq.sv
// BB ADC burst conversion sequencer.
// On STROBE && READBB it runs NCONV back-to-back conversions separated by PAUSE CE ticks,
// supervising ADCBUSY with a TMO-tick timeout, then raises DATAREADY until STROBE drops.
// All state advances only on CE ticks; RST is asynchronous and overrides CE.
// Ports:
//   CLK  clock
//   RST  asynchronous active-high reset
//   bus  bb_adc_seq_if.slave: CE, STROBE, READBB, ADCBUSY in; BBCONV, DATAREADY,
//        CONV_IDX (index of current/last conversion), TMO_ERR (sticky timeout) out
module bb_adc_seq #(
  parameter int unsigned NCONV = 2,
  parameter int unsigned PAUSE = 6,
  parameter int unsigned TMO   = 255,
  parameter int unsigned IW    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  bb_adc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StConv     = 3'd1,
    StWaitBusy = 3'd2,
    StPause    = 3'd3,
    StData     = 3'd4,
    StError    = 3'd5
  } state_e;

  localparam logic [15:0]   TmoLast   = 16'(TMO - 1);
  localparam logic [7:0]    PauseLast = 8'(PAUSE - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(NCONV - 1);

  state_e        state_q, state_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [7:0]    pause_q, pause_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          bbconv_q, dready_q;

  // Counters default to zero, so they clear on every state change and outside their
  // states; they only advance while the FSM stays put.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    pause_d = '0;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.STROBE && bus.READBB) begin
          state_d = StConv;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      StConv: begin
        if (bus.ADCBUSY)             state_d = StWaitBusy;
        else if (tmo_q == TmoLast)   state_d = StError;
        else                         tmo_d   = tmo_q + 16'd1;
      end
      StWaitBusy: begin
        if (!bus.ADCBUSY)            state_d = (idx_q == IdxLast) ? StData : StPause;
        else if (tmo_q == TmoLast)   state_d = StError;
        else                         tmo_d   = tmo_q + 16'd1;
      end
      StPause: begin
        if (pause_q == PauseLast) begin
          state_d = StConv;
          idx_d   = idx_q + IW'(1);
        end else begin
          pause_d = pause_q + 8'd1;
        end
      end
      StData: begin
        if (!bus.STROBE) state_d = StIdle;
      end
      StError: begin
        if (!bus.STROBE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StError && state_q != StError) err_d = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      pause_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      bbconv_q <= 1'b0;
      dready_q <= 1'b0;
    end else if (bus.CE) begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      pause_q  <= pause_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      bbconv_q <= (state_d == StConv);
      dready_q <= (state_d == StData);
    end
  end

  assign bus.BBCONV    = bbconv_q;
  assign bus.DATAREADY = dready_q;
  assign bus.CONV_IDX  = idx_q;
  assign bus.TMO_ERR   = err_q;

endmodule

// File: tb/tb_bb_adc_seq.sv
// Self-checking bench for bb_adc_seq. Three instances: defaults (b0), NCONV=4/PAUSE=1 (b1),
// TMO=8 with a dead ADC (b2). Expected conversion indices and the final DATAREADY are queued
// when a burst is started and checked by per-instance monitors as the outputs rise.
module tb_bb_adc_seq;
  localparam int Dr = 100;  // scoreboard token for a DATAREADY rise

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic ce  = 1'b1;
  int   ce_div = 1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  bb_adc_seq_if #(.IW(4)) b0 ();
  bb_adc_seq_if #(.IW(4)) b1 ();
  bb_adc_seq_if #(.IW(4)) b2 ();

  assign b0.CE = ce;
  assign b1.CE = ce;
  assign b2.CE = ce;

  bb_adc_seq #(.NCONV(2), .PAUSE(6), .TMO(255), .IW(4)) u0 (.CLK(CLK), .RST(RST), .bus(b0));
  bb_adc_seq #(.NCONV(4), .PAUSE(1), .TMO(255), .IW(4)) u1 (.CLK(CLK), .RST(RST), .bus(b1));
  bb_adc_seq #(.NCONV(2), .PAUSE(6), .TMO(8),   .IW(4)) u2 (.CLK(CLK), .RST(RST), .bus(b2));

  always #5 CLK = ~CLK;

  // CE pattern changes on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    ce  = (ce_div <= 1) || ((cyc % ce_div) == 0);
  end

  // ADC models: busy rises 3 CE ticks after a BBCONV rise is seen and stays up 10 ticks.
  int   t0 = 0, t1 = 0;
  logic cp0 = 1'b0, cp1 = 1'b0;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      t0 <= 0; cp0 <= 1'b0; b0.ADCBUSY <= 1'b0;
    end else if (ce) begin
      cp0 <= b0.BBCONV;
      if (b0.BBCONV && !cp0) t0 <= 1;
      else if (t0 != 0)      t0 <= (t0 == 12) ? 0 : t0 + 1;
      b0.ADCBUSY <= (t0 >= 2 && t0 < 12);
    end
  end
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      t1 <= 0; cp1 <= 1'b0; b1.ADCBUSY <= 1'b0;
    end else if (ce) begin
      cp1 <= b1.BBCONV;
      if (b1.BBCONV && !cp1) t1 <= 1;
      else if (t1 != 0)      t1 <= (t1 == 12) ? 0 : t1 + 1;
      b1.ADCBUSY <= (t1 >= 2 && t1 < 12);
    end
  end

  // Scoreboard monitors.
  int   q0[$], q1[$];
  int   e0, e1;
  logic mb0 = 1'b0, md0 = 1'b0, mb1 = 1'b0, md1 = 1'b0;
  always @(posedge CLK) begin
    #1;
    if ((b0.BBCONV && !mb0) || (b0.DATAREADY && !md0)) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL sb0: unexpected event bb=%0b dr=%0b idx=%0d, queue empty",
                 b0.BBCONV, b0.DATAREADY, b0.CONV_IDX);
      end else begin
        e0 = q0.pop_front();
        if (b0.DATAREADY && !md0) begin
          if (e0 !== Dr) begin
            fails++; $display("FAIL sb0_dr: got DATAREADY, expected conversion %0d", e0);
          end
        end else if (int'(b0.CONV_IDX) !== e0) begin
          fails++; $display("FAIL sb0_idx: got CONV_IDX=%0d expected %0d", b0.CONV_IDX, e0);
        end
      end
    end
    mb0 = b0.BBCONV; md0 = b0.DATAREADY;
  end
  always @(posedge CLK) begin
    #1;
    if ((b1.BBCONV && !mb1) || (b1.DATAREADY && !md1)) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1: unexpected event bb=%0b dr=%0b idx=%0d, queue empty",
                 b1.BBCONV, b1.DATAREADY, b1.CONV_IDX);
      end else begin
        e1 = q1.pop_front();
        if (b1.DATAREADY && !md1) begin
          if (e1 !== Dr) begin
            fails++; $display("FAIL sb1_dr: got DATAREADY, expected conversion %0d", e1);
          end
        end else if (int'(b1.CONV_IDX) !== e1) begin
          fails++; $display("FAIL sb1_idx: got CONV_IDX=%0d expected %0d", b1.CONV_IDX, e1);
        end
      end
    end
    mb1 = b1.BBCONV; md1 = b1.DATAREADY;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // {ADCBUSY, BBCONV, DATAREADY, TMO_ERR, CONV_IDX}
  function automatic logic [7:0] peek(input int dut);
    if (dut == 0) return {b0.ADCBUSY, b0.BBCONV, b0.DATAREADY, b0.TMO_ERR, b0.CONV_IDX};
    return {b1.ADCBUSY, b1.BBCONV, b1.DATAREADY, b1.TMO_ERR, b1.CONV_IDX};
  endfunction

  // Steps clocks until DATAREADY rises and measures the burst in CE ticks.
  // gap: CE samples with BBCONV low from the first sample showing ADCBUSY low up to the next
  // BBCONV rise (one WAIT_BUSY tick plus PAUSE ticks). dr_lat: CE samples from the last
  // ADCBUSY fall to DATAREADY. hold_viol: output changes seen across non-CE edges.
  task automatic walk(input int dut, input int max_ticks, output bit done, output int n_eps,
                      output int min_gap, output int max_gap, output int dr_lat,
                      output int first_rise, output int hold_viol);
    logic [7:0] cur, snap;
    logic       pbusy, pbb, in_gap;
    int         s, s_fall, gap;
    done = 0; n_eps = 0; min_gap = 1000; max_gap = -1; dr_lat = -1; first_rise = -1;
    hold_viol = 0; pbusy = 1'b0; pbb = 1'b0; in_gap = 1'b0; s = 0; s_fall = 0; gap = 0;
    snap = peek(dut);
    for (int k = 0; k < max_ticks && !done; k++) begin
      tick(1);
      cur = peek(dut);
      if (!ce) begin
        if (cur[6:0] !== snap[6:0]) hold_viol++;
      end else begin
        s++;
        if (pbusy && !cur[7]) begin s_fall = s; gap = 0; in_gap = 1'b1; end
        if (in_gap && !cur[6]) gap++;
        if (cur[6] && !pbb) begin
          n_eps++;
          if (first_rise < 0) first_rise = s;
          if (in_gap) begin
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
            in_gap = 1'b0;
          end
        end
        if (cur[5]) begin done = 1; dr_lat = s - s_fall; end
        pbusy = cur[7]; pbb = cur[6];
      end
      snap = cur;
    end
  endtask

  task automatic test_reset();
    #3 RST = 1'b1;
    tick(2);
    tests++;
    if ({b0.BBCONV, b0.DATAREADY, b0.TMO_ERR, b0.CONV_IDX} !== 7'd0) begin
      fails++; $display("FAIL reset_b0: got %b expected 0", {b0.BBCONV, b0.DATAREADY, b0.TMO_ERR, b0.CONV_IDX});
    end
    tests++;
    if ({b1.BBCONV, b1.DATAREADY, b1.TMO_ERR, b1.CONV_IDX} !== 7'd0) begin
      fails++; $display("FAIL reset_b1: got %b expected 0", {b1.BBCONV, b1.DATAREADY, b1.TMO_ERR, b1.CONV_IDX});
    end
    tests++;
    if ({b2.BBCONV, b2.DATAREADY, b2.TMO_ERR, b2.CONV_IDX} !== 7'd0) begin
      fails++; $display("FAIL reset_b2: got %b expected 0", {b2.BBCONV, b2.DATAREADY, b2.TMO_ERR, b2.CONV_IDX});
    end
    #3 RST = 1'b0;
    tick(2);
    tests++;
    if (b0.BBCONV !== 1'b0 || b1.BBCONV !== 1'b0 || b2.BBCONV !== 1'b0) begin
      fails++; $display("FAIL idle_hold: got BBCONV=%b%b%b expected 000", b0.BBCONV, b1.BBCONV, b2.BBCONV);
    end
  endtask

  task automatic test_burst();
    bit done; int n, mn, mx, lat, fr, hv;
    q0.push_back(0); q0.push_back(1); q0.push_back(Dr);
    b0.STROBE = 1'b1; b0.READBB = 1'b1;
    walk(0, 200, done, n, mn, mx, lat, fr, hv);
    tests++; if (!done) begin fails++; $display("FAIL burst_done: got no DATAREADY within 200 ticks, expected one"); end
    tests++; if (fr !== 1) begin fails++; $display("FAIL burst_latency: got first BBCONV at tick %0d expected 1", fr); end
    tests++; if (n !== 2) begin fails++; $display("FAIL burst_eps: got %0d BBCONV episodes expected 2", n); end
    tests++; if (mn !== 7 || mx !== 7) begin fails++; $display("FAIL burst_gap: got %0d..%0d expected 7", mn, mx); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL burst_dr_lat: got %0d expected 1", lat); end
    tick(5);
    tests++; if (b0.DATAREADY !== 1'b1) begin fails++; $display("FAIL burst_dr_hold: got %b expected 1", b0.DATAREADY); end
    b0.STROBE = 1'b0;
    tick(1);
    tests++;
    if (b0.DATAREADY !== 1'b0 || b0.BBCONV !== 1'b0) begin
      fails++; $display("FAIL burst_idle: got dr=%b bb=%b expected 0 0", b0.DATAREADY, b0.BBCONV);
    end
    tests++; if (q0.size() != 0) begin fails++; $display("FAIL burst_sb: got %0d pending expected 0", q0.size()); end
  endtask

  task automatic test_nconv4();
    bit done; int n, mn, mx, lat, fr, hv;
    for (int i = 0; i < 4; i++) q1.push_back(i);
    q1.push_back(Dr);
    b1.STROBE = 1'b1; b1.READBB = 1'b1;
    walk(1, 300, done, n, mn, mx, lat, fr, hv);
    tests++; if (!done) begin fails++; $display("FAIL n4_done: got no DATAREADY, expected one"); end
    tests++; if (n !== 4) begin fails++; $display("FAIL n4_eps: got %0d episodes expected 4", n); end
    tests++; if (mn !== 2 || mx !== 2) begin fails++; $display("FAIL n4_gap: got %0d..%0d expected 2", mn, mx); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL n4_dr_lat: got %0d expected 1", lat); end
    b1.STROBE = 1'b0;
    tick(2);
    tests++; if (q1.size() != 0 || b1.DATAREADY !== 1'b0) begin
      fails++; $display("FAIL n4_end: got pending=%0d dr=%b expected 0 0", q1.size(), b1.DATAREADY);
    end
  endtask

  task automatic test_timeout();
    int hi; bit fell;
    hi = 0; fell = 0;
    b2.STROBE = 1'b1; b2.READBB = 1'b1;
    for (int k = 0; k < 50 && !fell; k++) begin
      tick(1);
      if (b2.BBCONV) hi++;
      else fell = 1;
    end
    tests++; if (hi !== 8) begin fails++; $display("FAIL tmo_len: got BBCONV high %0d cycles expected 8", hi); end
    tests++; if (b2.TMO_ERR !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b expected 1", b2.TMO_ERR); end
    tick(3);
    tests++;
    if (b2.DATAREADY !== 1'b0 || b2.BBCONV !== 1'b0 || b2.TMO_ERR !== 1'b1) begin
      fails++; $display("FAIL tmo_hold: got dr=%b bb=%b err=%b expected 0 0 1", b2.DATAREADY, b2.BBCONV, b2.TMO_ERR);
    end
    b2.STROBE = 1'b0;
    tick(2);
    tests++; if (b2.TMO_ERR !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b expected 1", b2.TMO_ERR); end
    b2.STROBE = 1'b1;
    tick(1);
    tests++;
    if (b2.TMO_ERR !== 1'b0 || b2.BBCONV !== 1'b1) begin
      fails++; $display("FAIL tmo_clear: got err=%b bb=%b expected 0 1", b2.TMO_ERR, b2.BBCONV);
    end
    b2.STROBE = 1'b0;
    tick(12);
  endtask

  task automatic test_ce_gated();
    bit done; int n, mn, mx, lat, fr, hv;
    ce_div = 4;
    tick(4);
    q0.push_back(0); q0.push_back(1); q0.push_back(Dr);
    b0.STROBE = 1'b1; b0.READBB = 1'b1;
    walk(0, 800, done, n, mn, mx, lat, fr, hv);
    tests++; if (!done) begin fails++; $display("FAIL ce_done: got no DATAREADY, expected one"); end
    tests++; if (fr !== 1) begin fails++; $display("FAIL ce_latency: got tick %0d expected 1", fr); end
    tests++; if (n !== 2) begin fails++; $display("FAIL ce_eps: got %0d expected 2", n); end
    tests++; if (mn !== 7 || mx !== 7) begin fails++; $display("FAIL ce_gap: got %0d..%0d expected 7", mn, mx); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL ce_dr_lat: got %0d expected 1", lat); end
    tests++; if (hv !== 0) begin fails++; $display("FAIL ce_hold: got %0d changes on CE=0 edges expected 0", hv); end
    b0.STROBE = 1'b0;
    tick(8);
    tests++; if (b0.DATAREADY !== 1'b0) begin fails++; $display("FAIL ce_idle: got dr=%b expected 0", b0.DATAREADY); end
    ce_div = 1;
    tick(2);
  endtask

  task automatic test_strobe_drop();
    bit done, seen, fell; int n, mn, mx, lat, fr, hv, bbc;
    seen = 0; fell = 0; bbc = 0;
    q0.push_back(0); q0.push_back(1); q0.push_back(Dr);
    b0.STROBE = 1'b1; b0.READBB = 1'b1;
    for (int k = 0; k < 60 && !fell; k++) begin
      tick(1);
      if (b0.ADCBUSY) seen = 1;
      else if (seen) fell = 1;
    end
    tick(2);
    b0.STROBE = 1'b0;
    walk(0, 200, done, n, mn, mx, lat, fr, hv);
    tests++; if (!done || n !== 1) begin fails++; $display("FAIL drop_done: got done=%0b eps=%0d expected 1 1", done, n); end
    tick(1);
    tests++;
    if (b0.DATAREADY !== 1'b0 || b0.BBCONV !== 1'b0) begin
      fails++; $display("FAIL drop_pulse: got dr=%b bb=%b expected 0 0", b0.DATAREADY, b0.BBCONV);
    end
    b0.READBB = 1'b0; b0.STROBE = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (b0.BBCONV) bbc++;
    end
    tests++; if (bbc !== 0) begin fails++; $display("FAIL readbb_gate: got %0d BBCONV cycles expected 0", bbc); end
    b0.STROBE = 1'b0;
    tests++; if (q0.size() != 0) begin fails++; $display("FAIL drop_sb: got %0d pending expected 0", q0.size()); end
  endtask

  task automatic test_async_reset();
    bit found, done; int n, mn, mx, lat, fr, hv;
    found = 0;
    q0.push_back(0); q0.push_back(1); q0.push_back(Dr);
    b0.STROBE = 1'b1; b0.READBB = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      tick(1);
      if (b0.CONV_IDX == 4'd1 && !b0.BBCONV && b0.ADCBUSY) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL rst_reach: got no WAIT_BUSY on conversion 1, expected it"); end
    #3 RST = 1'b1;
    #1;
    tests++;
    if ({b0.BBCONV, b0.DATAREADY, b0.TMO_ERR, b0.CONV_IDX} !== 7'd0) begin
      fails++; $display("FAIL rst_async: got %b expected 0", {b0.BBCONV, b0.DATAREADY, b0.TMO_ERR, b0.CONV_IDX});
    end
    q0.delete();
    b0.STROBE = 1'b0;
    #2 RST = 1'b0;
    tick(2);
    q0.push_back(0); q0.push_back(1); q0.push_back(Dr);
    b0.STROBE = 1'b1;
    walk(0, 200, done, n, mn, mx, lat, fr, hv);
    tests++; if (!done || fr !== 1) begin fails++; $display("FAIL rst_restart: got done=%0b first=%0d expected 1 1", done, fr); end
    b0.STROBE = 1'b0;
    tick(2);
    tests++; if (q0.size() != 0) begin fails++; $display("FAIL rst_sb: got %0d pending expected 0", q0.size()); end
  endtask

  initial begin
    b0.STROBE = 1'b0; b0.READBB = 1'b0;
    b1.STROBE = 1'b0; b1.READBB = 1'b0;
    b2.STROBE = 1'b0; b2.READBB = 1'b0; b2.ADCBUSY = 1'b0;
    test_reset();
    test_burst();
    test_nconv4();
    test_timeout();
    test_ce_gated();
    test_strobe_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion by 300000, expected earlier finish");
    $fatal(1, "watchdog");
  end
endmodule
